// File: rtl/trap_controller.sv
// Machine-mode trap controller: mstatus/mtvec/mepc/mcause CSRs plus a RUN/TRAP/RET redirect FSM.
// Optional feature: define VECTORED_MODE_EN to enable vectored interrupt dispatch via mtvec[1:0]=2'b01.
module trap_controller #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        interrupt,
    input  logic [30:0] intCode,
    input  logic        instrRetire,
    input  logic [31:0] nextPc,
    input  logic        mret,
    input  logic        csrWe,
    input  logic [11:0] csrAddr,
    input  logic [31:0] csrWdata,
    output logic [31:0] csrRdata,
    output logic        trapTaken,
    output logic        mretTaken,
    output logic [31:0] trapTarget
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;

    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] ADDR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
`ifdef VECTORED_MODE_EN
    localparam logic [XLEN-1:0] MTVEC_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [XLEN-1:0] MTVEC_MASK = ALIGN_MASK;
`endif

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TRAP = 2'd1,
        RET  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_mie, r_mpie, w_mie_nxt, w_mpie_nxt;
    logic [XLEN-1:0] r_mtvec, r_mepc, r_mcause;
    logic [XLEN-1:0] w_mtvec_nxt, w_mepc_nxt, w_mcause_nxt;
    logic            w_trap_taken_nxt, w_mret_taken_nxt;
    logic [XLEN-1:0] w_target_nxt;
    logic [XLEN-1:0] w_vector;
    logic            w_take_trap, w_take_mret;

    // Trap vector: direct base, or base + 4*cause when vectored mode is selected.
    always_comb begin
        w_vector = r_mtvec & ALIGN_MASK;
`ifdef VECTORED_MODE_EN
        if (r_mtvec[1:0] == 2'b01) begin
            w_vector = (r_mtvec & ALIGN_MASK) + {intCode[29:0], 2'b00};
        end
`endif
    end

    // Next-state, CSR update and registered-output computation.
    always_comb begin
        w_state_nxt      = r_state;
        w_mie_nxt        = r_mie;
        w_mpie_nxt       = r_mpie;
        w_mtvec_nxt      = r_mtvec;
        w_mepc_nxt       = r_mepc;
        w_mcause_nxt     = r_mcause;
        w_trap_taken_nxt = 1'b0;
        w_mret_taken_nxt = 1'b0;
        w_target_nxt     = '0;
        w_take_trap      = (r_state == RUN) && interrupt && r_mie && instrRetire;
        w_take_mret      = (r_state == RUN) && instrRetire && mret && !w_take_trap;

        if (csrWe) begin
            case (csrAddr)
                ADDR_MSTATUS: begin
                    w_mie_nxt  = csrWdata[3];
                    w_mpie_nxt = csrWdata[7];
                end
                ADDR_MTVEC:  w_mtvec_nxt  = csrWdata & MTVEC_MASK;
                ADDR_MEPC:   w_mepc_nxt   = csrWdata & ALIGN_MASK;
                ADDR_MCAUSE: w_mcause_nxt = csrWdata;
                default: ;
            endcase
        end

        // Hardware updates are applied last so they override a same-edge CSR write.
        case (r_state)
            RUN: begin
                if (w_take_trap) begin
                    w_mepc_nxt       = nextPc & ALIGN_MASK;
                    w_mcause_nxt     = {1'b1, intCode};
                    w_mpie_nxt       = r_mie;
                    w_mie_nxt        = 1'b0;
                    w_state_nxt      = TRAP;
                    w_trap_taken_nxt = 1'b1;
                    w_target_nxt     = w_vector;
                end else if (w_take_mret) begin
                    w_mie_nxt        = r_mpie;
                    w_mpie_nxt       = 1'b1;
                    w_state_nxt      = RET;
                    w_mret_taken_nxt = 1'b1;
                    w_target_nxt     = r_mepc;
                end
            end
            TRAP:    w_state_nxt = RUN;
            RET:     w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= RESET_MTVEC & MTVEC_MASK;
            r_mepc     <= '0;
            r_mcause   <= '0;
            trapTaken  <= 1'b0;
            mretTaken  <= 1'b0;
            trapTarget <= '0;
        end else begin
            r_mie      <= w_mie_nxt;
            r_mpie     <= w_mpie_nxt;
            r_mtvec    <= w_mtvec_nxt;
            r_mepc     <= w_mepc_nxt;
            r_mcause   <= w_mcause_nxt;
            trapTaken  <= w_trap_taken_nxt;
            mretTaken  <= w_mret_taken_nxt;
            trapTarget <= w_target_nxt;
        end
    end

    // Combinational CSR read; unimplemented addresses return zero.
    always_comb begin
        csrRdata = '0;
        case (csrAddr)
            ADDR_MSTATUS: csrRdata = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
            ADDR_MTVEC:   csrRdata = r_mtvec;
            ADDR_MEPC:    csrRdata = r_mepc;
            ADDR_MCAUSE:  csrRdata = r_mcause;
            default:      csrRdata = '0;
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller; expected values are hand-computed constants.
// Honours VECTORED_MODE_EN so the same bench covers both builds.
module tb_trap_controller;

    localparam logic [31:0] RST_VEC = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        resetn;
    logic        interrupt;
    logic [30:0] intCode;
    logic        instrRetire;
    logic [31:0] nextPc;
    logic        mret;
    logic        csrWe;
    logic [11:0] csrAddr;
    logic [31:0] csrWdata;
    logic [31:0] csrRdata;
    logic        trapTaken;
    logic        mretTaken;
    logic [31:0] trapTarget;

    int n_checks = 0;
    int n_pass   = 0;

    trap_controller #(.RESET_MTVEC(RST_VEC)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .interrupt  (interrupt),
        .intCode    (intCode),
        .instrRetire(instrRetire),
        .nextPc     (nextPc),
        .mret       (mret),
        .csrWe      (csrWe),
        .csrAddr    (csrAddr),
        .csrWdata   (csrWdata),
        .csrRdata   (csrRdata),
        .trapTaken  (trapTaken),
        .mretTaken  (mretTaken),
        .trapTarget (trapTarget)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
        csrWe    = 1'b1;
        csrAddr  = addr;
        csrWdata = data;
        step();
        csrWe    = 1'b0;
    endtask

    task automatic csr_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csrAddr = addr;
        #1;
        check(tag, csrRdata, exp);
    endtask

    task automatic idle();
        interrupt   = 1'b0;
        instrRetire = 1'b0;
        mret        = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        intCode  = '0;
        nextPc   = '0;
        csrWe    = 1'b0;
        csrAddr  = '0;
        csrWdata = '0;

        // Reset state
        step();
        step();
        check("rst_trapTaken", 32'(trapTaken), 32'd0);
        check("rst_mretTaken", 32'(mretTaken), 32'd0);
        check("rst_trapTarget", trapTarget, 32'd0);
        csr_chk("rst_mtvec", 12'h305, RST_VEC);
        csr_chk("rst_mstatus", 12'h300, 32'd0);
        resetn = 1'b1;
        step();

        // Basic trap
        csr_wr(12'h305, 32'h0000_0100);
        csr_wr(12'h300, 32'h0000_0008);
        csr_chk("mtvec_wr", 12'h305, 32'h0000_0100);
        csr_chk("unimpl_addr", 12'h123, 32'd0);
        interrupt = 1'b1; intCode = 31'd3; instrRetire = 1'b1; nextPc = 32'h0000_2000;
        step();
        idle();
        check("trap_taken", 32'(trapTaken), 32'd1);
        check("trap_target", trapTarget, 32'h0000_0100);
        check("trap_no_mret", 32'(mretTaken), 32'd0);
        csr_chk("trap_mepc", 12'h341, 32'h0000_2000);
        csr_chk("trap_mcause", 12'h342, 32'h8000_0003);
        csr_chk("trap_mstatus", 12'h300, 32'h0000_0080);
        step();
        check("trap_pulse_end", 32'(trapTaken), 32'd0);
        check("trap_target_zero", trapTarget, 32'd0);

        // Return
        instrRetire = 1'b1; mret = 1'b1;
        step();
        idle();
        check("ret_taken", 32'(mretTaken), 32'd1);
        check("ret_target", trapTarget, 32'h0000_2000);
        check("ret_no_trap", 32'(trapTaken), 32'd0);
        csr_chk("ret_mstatus", 12'h300, 32'h0000_0088);
        step();
        check("ret_pulse_end", 32'(mretTaken), 32'd0);

        // Masked interrupts
        csr_wr(12'h300, 32'h0000_0000);
        interrupt = 1'b1; instrRetire = 1'b1; nextPc = 32'h0000_7770;
        for (int i = 0; i < 10; i++) begin
            step();
            check("masked_trapTaken", 32'(trapTaken), 32'd0);
        end
        idle();
        csr_chk("masked_mepc", 12'h341, 32'h0000_2000);

        // Priority: interrupt and mret on the same edge; mret held through TRAP is ignored
        csr_wr(12'h300, 32'h0000_0008);
        interrupt = 1'b1; intCode = 31'd7; instrRetire = 1'b1; mret = 1'b1; nextPc = 32'h0000_3004;
        step();
        interrupt = 1'b0;
        check("prio_trap", 32'(trapTaken), 32'd1);
        check("prio_no_mret", 32'(mretTaken), 32'd0);
        check("prio_target", trapTarget, 32'h0000_0100);
        step();
        check("trap_ignores_mret", 32'(mretTaken), 32'd0);
        step();
        idle();
        check("later_mret", 32'(mretTaken), 32'd1);
        check("later_mret_target", trapTarget, 32'h0000_3004);
        csr_chk("prio_mcause", 12'h342, 32'h8000_0007);
        step();

        // Hardware update beats simultaneous CSR write
        interrupt = 1'b1; intCode = 31'd2; instrRetire = 1'b1; nextPc = 32'h0000_4000;
        csr_wr(12'h300, 32'h0000_0000);
        idle();
        check("coll_trap", 32'(trapTaken), 32'd1);
        csr_chk("coll_mstatus", 12'h300, 32'h0000_0080);
        step();

        // mepc low bits read zero
        csr_wr(12'h341, 32'h0000_5003);
        csr_chk("mepc_align", 12'h341, 32'h0000_5000);

        // Vectored / direct mode
        csr_wr(12'h305, 32'h0000_0101);
        csr_wr(12'h300, 32'h0000_0008);
`ifdef VECTORED_MODE_EN
        csr_chk("mtvec_mode", 12'h305, 32'h0000_0101);
`else
        csr_chk("mtvec_mode", 12'h305, 32'h0000_0100);
`endif
        interrupt = 1'b1; intCode = 31'd5; instrRetire = 1'b1; nextPc = 32'h0000_6000;
        step();
        idle();
        check("vec_trap", 32'(trapTaken), 32'd1);
`ifdef VECTORED_MODE_EN
        check("vec_target", trapTarget, 32'h0000_0114);
`else
        check("vec_target", trapTarget, 32'h0000_0100);
`endif

        // Async reset in the middle of TRAP
        #1;
        resetn = 1'b0;
        #1;
        check("arst_trapTaken", 32'(trapTaken), 32'd0);
        check("arst_trapTarget", trapTarget, 32'd0);
        csr_chk("arst_mstatus", 12'h300, 32'd0);
        csr_chk("arst_mtvec", 12'h305, RST_VEC);
        csr_chk("arst_mepc", 12'h341, 32'd0);
        csr_chk("arst_mcause", 12'h342, 32'd0);
        step();
        resetn = 1'b1;
        step();
        check("post_rst_idle", 32'(trapTaken), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
